// File: rtl/blake2s_block_buf.sv
// blake2s_block_buf: collects a byte stream into 64-byte message blocks for a
// BLAKE2s compression core. Two ping-pong buffers let one block wait for the
// core while the next is being filled. Each closed block carries its byte
// counter t and first/last flags. Short final blocks are zero padded.
module blake2s_block_buf #(
  parameter int BLOCK_BYTES = 64
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     clear_i,
  input  logic                     data_v_i,
  input  logic [7:0]               data_i,
  input  logic [63:0]              ll_i,
  output logic                     blk_v_o,
  input  logic                     blk_ready_i,
  output logic [8*BLOCK_BYTES-1:0] m_o,
  output logic [63:0]              t_o,
  output logic                     first_o,
  output logic                     last_o,
  output logic                     overflow_o
);

  localparam int         BLK_W     = 8 * BLOCK_BYTES;
  localparam logic [5:0] FILL_LAST = 6'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_t;

  // Write-side and read-side bookkeeping shared by both buffers
  logic        wr_sel_reg;
  logic        rd_sel_reg;
  logic [5:0]  fill_reg;
  logic [63:0] cnt_reg;
  logic        overflow_reg;

  // Per-buffer views, one element per ping-pong buffer
  logic [1:0][BLK_W-1:0] blk_bus;
  logic [1:0][63:0]      t_bus;
  logic [1:0]            first_vec;
  logic [1:0]            last_vec;
  logic [1:0]            full_vec;

  logic [63:0] cnt_next;
  logic        is_last;
  logic        byte_ok;
  logic        byte_drop;
  logic        blk_close;
  logic        pop;

  assign cnt_next  = cnt_reg + 64'd1;
  assign is_last   = (cnt_next == ll_i);
  // A byte is stored only when the buffer being written still has room;
  // clear_i suppresses both storing and the overflow flag.
  assign byte_ok   = data_v_i & ~clear_i & ~full_vec[wr_sel_reg];
  assign byte_drop = data_v_i & ~clear_i &  full_vec[wr_sel_reg];
  assign blk_close = byte_ok & ((fill_reg == FILL_LAST) | is_last);
  // Pop and close can never hit the same buffer: a close needs the write
  // buffer not FULL, a pop needs the read buffer FULL.
  assign pop       = full_vec[rd_sel_reg] & blk_ready_i & ~clear_i;

  // Fill position, message byte count, buffer pointers and sticky overflow
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_sel_reg   <= 1'b0;
      rd_sel_reg   <= 1'b0;
      fill_reg     <= 6'd0;
      cnt_reg      <= 64'd0;
      overflow_reg <= 1'b0;
    end else if (clear_i) begin
      wr_sel_reg   <= 1'b0;
      rd_sel_reg   <= 1'b0;
      fill_reg     <= 6'd0;
      cnt_reg      <= 64'd0;
      overflow_reg <= 1'b0;
    end else begin
      if (byte_ok) begin
        if (blk_close) begin
          fill_reg   <= 6'd0;
          wr_sel_reg <= ~wr_sel_reg;
        end else begin
          fill_reg   <= fill_reg + 6'd1;
        end
        // The final byte of a message rewinds the count for the next one
        cnt_reg <= is_last ? 64'd0 : cnt_next;
      end
      if (pop) begin
        rd_sel_reg <= ~rd_sel_reg;
      end
      if (byte_drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      buf_state_t      state_reg;
      logic [BLK_W-1:0] data_reg;
      logic [63:0]      t_reg;
      logic             first_reg;
      logic             last_reg;
      logic             wr_hit;
      logic             pop_hit;

      assign wr_hit  = byte_ok & (wr_sel_reg == 1'(gi));
      assign pop_hit = pop & (rd_sel_reg == 1'(gi));

      // Buffer contents and state; popping zeroes it so later short
      // blocks come out zero padded
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          state_reg <= BUF_EMPTY;
          data_reg  <= '0;
          t_reg     <= 64'd0;
          first_reg <= 1'b0;
          last_reg  <= 1'b0;
        end else if (clear_i || pop_hit) begin
          state_reg <= BUF_EMPTY;
          data_reg  <= '0;
          t_reg     <= 64'd0;
          first_reg <= 1'b0;
          last_reg  <= 1'b0;
        end else if (wr_hit) begin
          data_reg[{fill_reg, 3'b000} +: 8] <= data_i;
          if (blk_close) begin
            state_reg <= BUF_FULL;
            t_reg     <= cnt_next;
            last_reg  <= is_last;
            first_reg <= (cnt_next <= 64'(BLOCK_BYTES));
          end else begin
            state_reg <= BUF_FILLING;
          end
        end
      end

      assign blk_bus[gi]   = data_reg;
      assign t_bus[gi]     = t_reg;
      assign first_vec[gi] = first_reg;
      assign last_vec[gi]  = last_reg;
      assign full_vec[gi]  = (state_reg == BUF_FULL);
    end
  endgenerate

  // Present the read buffer only once it is FULL; otherwise everything is zero
  assign blk_v_o    = full_vec[rd_sel_reg];
  assign m_o        = blk_v_o ? blk_bus[rd_sel_reg] : '0;
  assign t_o        = blk_v_o ? t_bus[rd_sel_reg] : 64'd0;
  assign first_o    = blk_v_o & first_vec[rd_sel_reg];
  assign last_o     = blk_v_o & last_vec[rd_sel_reg];
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_blake2s_block_buf.sv
// Directed bench for blake2s_block_buf: short message, two-block message,
// overflow, pop/close overlap, async reset mid-message and synchronous clear.
module tb_blake2s_block_buf;

  logic         clk = 1'b0;
  logic         nreset;
  logic         clear_i;
  logic         data_v_i;
  logic [7:0]   data_i;
  logic [63:0]  ll_i;
  logic         blk_v_o;
  logic         blk_ready_i;
  logic [511:0] m_o;
  logic [63:0]  t_o;
  logic         first_o;
  logic         last_o;
  logic         overflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [511:0] exp_m;

  always #5 clk = ~clk;

  blake2s_block_buf #(.BLOCK_BYTES(64)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .clear_i     (clear_i),
    .data_v_i    (data_v_i),
    .data_i      (data_i),
    .ll_i        (ll_i),
    .blk_v_o     (blk_v_o),
    .blk_ready_i (blk_ready_i),
    .m_o         (m_o),
    .t_o         (t_o),
    .first_o     (first_o),
    .last_o      (last_o),
    .overflow_o  (overflow_o)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Step to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    data_v_i = 1'b1;
    data_i   = b;
    tick();
    data_v_i = 1'b0;
  endtask

  initial begin
    nreset      = 1'b0;
    clear_i     = 1'b0;
    data_v_i    = 1'b0;
    data_i      = 8'h00;
    ll_i        = 64'd0;
    blk_ready_i = 1'b0;
    #1;
    check("rst_blk_v", 512'(blk_v_o), 512'd0);
    check("rst_m", m_o, 512'd0);
    check("rst_t", 512'(t_o), 512'd0);
    check("rst_ovf", 512'(overflow_o), 512'd0);
    tick();
    tick();
    nreset = 1'b1;
    tick();

    // Three-byte message "abc", core always ready
    ll_i = 64'd3;
    blk_ready_i = 1'b1;
    send(8'h61);
    check("abc_early_v", 512'(blk_v_o), 512'd0);
    send(8'h62);
    send(8'h63);
    check("abc_v", 512'(blk_v_o), 512'd1);
    check("abc_m", m_o, 512'h636261);
    check("abc_t", 512'(t_o), 512'd3);
    check("abc_first", 512'(first_o), 512'd1);
    check("abc_last", 512'(last_o), 512'd1);
    tick();
    check("abc_popped", 512'(blk_v_o), 512'd0);
    $display("[TB] abc message: t=3 single block");

    // 128-byte message, core stalled until both blocks are buffered
    ll_i = 64'd128;
    blk_ready_i = 1'b0;
    for (int i = 0; i < 128; i++) send(8'(i));
    exp_m = '0;
    for (int i = 0; i < 64; i++) exp_m[8*i +: 8] = 8'(i);
    check("two_a_v", 512'(blk_v_o), 512'd1);
    check("two_a_m", m_o, exp_m);
    check("two_a_m_hi", 512'(m_o[511:504]), 512'h3f);
    check("two_a_t", 512'(t_o), 512'd64);
    check("two_a_first", 512'(first_o), 512'd1);
    check("two_a_last", 512'(last_o), 512'd0);
    blk_ready_i = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) exp_m[8*i +: 8] = 8'(64 + i);
    check("two_b_v", 512'(blk_v_o), 512'd1);
    check("two_b_m", m_o, exp_m);
    check("two_b_t", 512'(t_o), 512'd128);
    check("two_b_first", 512'(first_o), 512'd0);
    check("two_b_last", 512'(last_o), 512'd1);
    tick();
    check("two_done", 512'(blk_v_o), 512'd0);
    blk_ready_i = 1'b0;
    $display("[TB] 128-byte message: blocks t=64 and t=128");

    // Overflow: both buffers full, byte 128 dropped
    ll_i = 64'd200;
    for (int i = 0; i < 128; i++) send(8'(i));
    check("ovf_before", 512'(overflow_o), 512'd0);
    send(8'h80);
    for (int i = 0; i < 64; i++) exp_m[8*i +: 8] = 8'(i);
    check("ovf_flag", 512'(overflow_o), 512'd1);
    check("ovf_v", 512'(blk_v_o), 512'd1);
    check("ovf_m", m_o, exp_m);
    check("ovf_t", 512'(t_o), 512'd64);
    check("ovf_first", 512'(first_o), 512'd1);
    check("ovf_last", 512'(last_o), 512'd0);
    $display("[TB] overflow: byte 128 dropped, flag set");

    // Clear with a block pending and a byte present in the same cycle
    ll_i     = 64'd1;
    clear_i  = 1'b1;
    data_v_i = 1'b1;
    data_i   = 8'hAA;
    blk_ready_i = 1'b1;
    tick();
    clear_i  = 1'b0;
    data_v_i = 1'b0;
    blk_ready_i = 1'b0;
    check("clr_v", 512'(blk_v_o), 512'd0);
    check("clr_ovf", 512'(overflow_o), 512'd0);
    check("clr_t", 512'(t_o), 512'd0);
    send(8'h55);
    check("clr_next_v", 512'(blk_v_o), 512'd1);
    check("clr_next_m", m_o, 512'h55);
    check("clr_next_t", 512'(t_o), 512'd1);
    check("clr_next_flags", 512'({first_o, last_o}), 512'b11);
    blk_ready_i = 1'b1;
    tick();
    blk_ready_i = 1'b0;
    check("clr_next_pop", 512'(blk_v_o), 512'd0);
    $display("[TB] clear: pending block and same-cycle byte discarded");

    // 70-byte message, pop of block 1 coincides with the closing byte
    ll_i = 64'd70;
    for (int i = 0; i < 69; i++) send(8'(i));
    check("ov_a_t", 512'(t_o), 512'd64);
    blk_ready_i = 1'b1;
    send(8'd69);
    exp_m = '0;
    for (int i = 0; i < 6; i++) exp_m[8*i +: 8] = 8'(64 + i);
    check("ov_b_v", 512'(blk_v_o), 512'd1);
    check("ov_b_m", m_o, exp_m);
    check("ov_b_m48", 512'(m_o[47:0]), 512'h454443424140);
    check("ov_b_t", 512'(t_o), 512'd70);
    check("ov_b_flags", 512'({first_o, last_o}), 512'b01);
    tick();
    blk_ready_i = 1'b0;
    check("ov_done", 512'(blk_v_o), 512'd0);
    $display("[TB] 70-byte message: pop and close in one cycle");

    // Async reset with a block pending and a partial block in progress
    ll_i = 64'd128;
    for (int i = 0; i < 74; i++) send(8'(i));
    check("ar_pending", 512'(blk_v_o), 512'd1);
    #2;
    nreset = 1'b0;
    #1;
    check("ar_v", 512'(blk_v_o), 512'd0);
    check("ar_m", m_o, 512'd0);
    check("ar_t", 512'(t_o), 512'd0);
    check("ar_flags", 512'({first_o, last_o, overflow_o}), 512'd0);
    tick();
    nreset = 1'b1;
    ll_i = 64'd64;
    for (int i = 0; i < 64; i++) send(8'(8'h80 + i));
    exp_m = '0;
    for (int i = 0; i < 64; i++) exp_m[8*i +: 8] = 8'(8'h80 + i);
    check("ar_new_v", 512'(blk_v_o), 512'd1);
    check("ar_new_m", m_o, exp_m);
    check("ar_new_t", 512'(t_o), 512'd64);
    check("ar_new_flags", 512'({first_o, last_o}), 512'b11);
    $display("[TB] async reset: partial message discarded, new t=64");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
